filtered_edge_detector: RTL

FILTERED_EDGE_DETECTOR -- requirements
Module: filtered_edge_detector

---
 rtl/filtered_edge_detector.sv | 108 ++++++++++
 1 files changed

// File: rtl/filtered_edge_detector.sv
// Multi-channel synchronizer, debounce filter and mode-qualified edge detector with a saturating event counter.
// d_filt/rise/fall/edge_detect update SYNC_STAGES+FILTER_LEN-1 edges after a stable input change is first sampled.
module filtered_edge_detector #(
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int RESET_LEVEL = 1,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [NUM_CH-1:0] d_in,
  input  logic [1:0]        mode,
  input  logic              clr_count,
  output logic [NUM_CH-1:0] d_filt,
  output logic [NUM_CH-1:0] edge_detect,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic [CNT_W-1:0]  edge_count
);

  localparam int             FCW       = $clog2(FILTER_LEN + 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic           RST_BIT   = 1'(RESET_LEVEL);

  localparam logic [1:0] MODE_ANY  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0]                  s;
  logic [NUM_CH-1:0][FCW-1:0]         cnt_q, cnt_d;
  logic [NUM_CH-1:0]                  filt_q, filt_d;
  logic [NUM_CH-1:0]                  rise_q, rise_d, fall_q, fall_d, edet_q, edet_d;
  logic [CNT_W-1:0]                   ecnt_q, ecnt_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= {(SYNC_STAGES*NUM_CH){RST_BIT}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // The level flips on the FILTER_LEN-th consecutive mismatching cycle; any match restarts the count.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == FILT_LAST) begin
        filt_d[i] = s[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    rise_d = filt_d & ~filt_q;
    fall_d = ~filt_d & filt_q;
    case (mode)
      MODE_ANY:  edet_d = rise_d | fall_d;
      MODE_RISE: edet_d = rise_d;
      MODE_FALL: edet_d = fall_d;
      default:   edet_d = '0;
    endcase
  end

  // Counts in step with the registered pulse, so a clear on the same edge wins.
  always_comb begin
    ecnt_d = ecnt_q;
    if (clr_count) begin
      ecnt_d = '0;
    end else if ((|edet_d) && (ecnt_q != {CNT_W{1'b1}})) begin
      ecnt_d = ecnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q  <= '0;
      filt_q <= {NUM_CH{RST_BIT}};
      rise_q <= '0;
      fall_q <= '0;
      edet_q <= '0;
      ecnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      edet_q <= edet_d;
      ecnt_q <= ecnt_d;
    end
  end

  assign d_filt      = filt_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign edge_detect = edet_q;
  assign edge_count  = ecnt_q;

endmodule
